divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/divider_pkg.sv | 11 +
 rtl/divider_if.sv | 28 ++
 rtl/divider_iter_counter.sv | 33 +++
 rtl/divider.sv | 115 +++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the controller state encoding used by the top level.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/divider_if.sv
// Request/response bundle for the divider.
//   master: drives start/dividend/divisor, observes ready/done/results
//   slave : the divider itself
interface divider_if #(
    parameter int N = 4
);
    import divider_pkg::*;

    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         ready;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  ready, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output ready, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/divider_iter_counter.sv
// Iteration counter for the divider.
//   clock, reset  : rising-edge clock, synchronous active-high reset (to 0)
//   do_preset     : load N-1 (start of a division)
//   do_decrement  : count down by one (one restoring step); wins over preset
//   is_zero       : counter currently 0 (current step is the last one)
module divider_iter_counter
    import divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic do_preset,
    input  logic do_decrement,
    output logic is_zero
);

    localparam int W = $clog2(N);

    logic [W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset)
            count_q <= '0;
        else if (do_decrement)
            count_q <= count_q - 1'b1;
        else if (do_preset)
            count_q <= W'(N - 1);
    end

    assign is_zero = (count_q == '0);

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : start/dividend/divisor in; ready/done/quotient/
//                  remainder/div_by_zero out
// A nonzero-divisor division spends N cycles in RUN; a zero divisor goes
// straight to DONE with quotient all ones and remainder = dividend.
module divider
    import divider_pkg::*;
#(
    parameter int N = 4
) (
    input  logic       clock,
    input  logic       reset,
    divider_if.slave   bus
);

    state_t       state_q, state_d;
    logic         accept;
    logic         cnt_zero;

    logic [N:0]   rem_q;        // partial remainder
    logic [N-1:0] dvd_q;        // dividend shifts out, quotient shifts in
    logic [N-1:0] dsr_q;
    logic [N-1:0] quo_q, rmd_q;
    logic         dbz_q;

    logic [N:0]   rem_shift, trial, rem_next;
    logic         q_bit;

    // A restoring step keeps the remainder below the divisor, so the top
    // bit of the stored partial remainder is always 0 on entry to a step.
    logic         unused_rem_msb;
    assign unused_rem_msb = rem_q[N];

    assign accept    = (state_q == IDLE) && bus.start;

    // Single N+1-bit subtractor; its sign bit selects restore vs keep.
    assign rem_shift = {rem_q[N-1:0], dvd_q[N-1]};
    assign trial     = rem_shift - {1'b0, dsr_q};
    assign q_bit     = ~trial[N];
    assign rem_next  = q_bit ? trial : rem_shift;

    divider_iter_counter #(.N(N)) u_cnt (
        .clock        (clock),
        .reset        (reset),
        .do_preset    (accept),
        .do_decrement (state_q == RUN),
        .is_zero      (cnt_zero)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        bus.ready = 1'b0;
        bus.done  = 1'b0;
        case (state_q)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start)
                    state_d = (bus.divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cnt_zero)
                    state_d = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem_q <= '0;
            dvd_q <= '0;
            dsr_q <= '0;
            quo_q <= '0;
            rmd_q <= '0;
            dbz_q <= 1'b0;
        end else begin
            if (accept) begin
                rem_q <= '0;
                dvd_q <= bus.dividend;
                dsr_q <= bus.divisor;
                if (bus.divisor == '0) begin
                    quo_q <= '1;
                    rmd_q <= bus.dividend;
                    dbz_q <= 1'b1;
                end
            end else if (state_q == RUN) begin
                rem_q <= rem_next;
                dvd_q <= {dvd_q[N-2:0], q_bit};
                // Results are published only on the step that enters DONE.
                if (cnt_zero) begin
                    quo_q <= {dvd_q[N-2:0], q_bit};
                    rmd_q <= rem_next[N-1:0];
                    dbz_q <= 1'b0;
                end
            end
        end
    end

    assign bus.quotient    = quo_q;
    assign bus.remainder   = rmd_q;
    assign bus.div_by_zero = dbz_q;

endmodule
